// File: rtl/i2c_bit_sequencer.sv
// I2C bit-level sequencer: expands START/STOP/WRITE/READ commands into timed SCL/SDA
// phases paced by an external cycle timer, with clock stretching and arbitration checks.
module i2c_bit_sequencer #(
  parameter int BIT_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_type,
  input  logic                 cmd_bit,
  input  logic [BIT_WIDTH-1:0] half_period,
  output logic                 rsp_valid,
  output logic                 rsp_bit,
  output logic                 rsp_arb_lost,
  output logic                 rsp_error,
  output logic                 timer_enable,
  output logic                 timer_load,
  output logic [BIT_WIDTH-1:0] timer_count,
  input  logic                 timer_expired,
  output logic                 scl_drive_low,
  output logic                 sda_drive_low,
  input  logic                 scl_in,
  input  logic                 sda_in
);

  localparam logic [1:0] CMD_START = 2'd0;
  localparam logic [1:0] CMD_STOP  = 2'd1;
  localparam logic [1:0] CMD_WRITE = 2'd2;
  localparam logic [1:0] CMD_READ  = 2'd3;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_t;

  state_t               state_reg;
  logic [1:0]           cmd_type_reg;
  logic                 cmd_bit_reg;
  logic [BIT_WIDTH-1:0] n_reg;
  logic [1:0]           phase_idx_reg;
  logic                 repeated_reg;
  logic                 loaded_reg;
  logic                 owned_reg;
  logic                 scl_low_reg;
  logic                 sda_low_reg;
  logic                 rsp_valid_reg;
  logic                 rsp_bit_reg;
  logic                 rsp_arb_reg;
  logic                 rsp_err_reg;

  // {scl_low, sda_low} for each phase. A START on a free bus begins at index 1,
  // skipping the (SCL low, SDA released) setup phase used only by a repeated start.
  function automatic logic [1:0] phase_drive(input logic [1:0] ctype, input logic cbit,
                                             input logic [1:0] idx);
    logic [1:0] drv;
    drv = 2'b00;
    case (ctype)
      CMD_START: begin
        case (idx)
          2'd0:    drv = 2'b10;
          2'd1:    drv = 2'b00;
          2'd2:    drv = 2'b01;
          default: drv = 2'b11;
        endcase
      end
      CMD_STOP: begin
        case (idx)
          2'd0:    drv = 2'b11;
          2'd1:    drv = 2'b01;
          default: drv = 2'b00;
        endcase
      end
      CMD_WRITE: drv = {idx == 2'd0, ~cbit};
      default:   drv = {idx == 2'd0, 1'b0};
    endcase
    return drv;
  endfunction

  function automatic logic [1:0] last_phase_idx(input logic [1:0] ctype);
    logic [1:0] idx;
    case (ctype)
      CMD_START: idx = 2'd3;
      CMD_STOP:  idx = 2'd2;
      default:   idx = 2'd1;
    endcase
    return idx;
  endfunction

  logic                 running;
  logic                 cmd_legal;
  logic [1:0]           first_idx;
  logic [BIT_WIDTH-1:0] n_capture;
  logic                 phase_end;
  logic                 start_first_phase;
  logic                 arb_lost_now;
  logic                 done_now;
  logic                 owned_after;
  logic [1:0]           next_idx;
  logic [1:0]           next_drive;
  logic [1:0]           first_drive;

  always_comb begin
    running     = (state_reg == ST_RUN);
    cmd_legal   = (cmd_type == CMD_START) || owned_reg;
    first_idx   = ((cmd_type == CMD_START) && !owned_reg) ? 2'd1 : 2'd0;
    first_drive = phase_drive(cmd_type, cmd_bit, first_idx);
    n_capture   = (half_period == '0) ? {{(BIT_WIDTH-1){1'b0}}, 1'b1} : half_period;

    // SCL-released phases only start timing once the line is really high.
    timer_load   = running && !loaded_reg && (scl_low_reg || scl_in) && !reset;
    timer_enable = running && !reset;
    timer_count  = n_reg;
    cmd_ready    = (state_reg == ST_IDLE);

    phase_end = running && loaded_reg && !timer_load && timer_expired;

    start_first_phase = (cmd_type_reg == CMD_START) && !repeated_reg &&
                        (phase_idx_reg == 2'd1);
    // A READ samples the slave's data, so a low SDA there is not lost arbitration.
    arb_lost_now = phase_end && !scl_low_reg &&
                   ((!sda_low_reg && !sda_in && (cmd_type_reg != CMD_READ)) ||
                    (start_first_phase && (!scl_in || !sda_in)));
    done_now = phase_end &&
               ((phase_idx_reg == last_phase_idx(cmd_type_reg)) || arb_lost_now);

    owned_after = owned_reg;
    if (arb_lost_now) begin
      owned_after = 1'b0;
    end else if (cmd_type_reg == CMD_START) begin
      owned_after = 1'b1;
    end else if (cmd_type_reg == CMD_STOP) begin
      owned_after = 1'b0;
    end

    next_idx   = phase_idx_reg + 2'd1;
    next_drive = phase_drive(cmd_type_reg, cmd_bit_reg, next_idx);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      cmd_type_reg  <= CMD_START;
      cmd_bit_reg   <= 1'b0;
      n_reg         <= {{(BIT_WIDTH-1){1'b0}}, 1'b1};
      phase_idx_reg <= 2'd0;
      repeated_reg  <= 1'b0;
      loaded_reg    <= 1'b0;
      owned_reg     <= 1'b0;
      scl_low_reg   <= 1'b0;
      sda_low_reg   <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_bit_reg   <= 1'b0;
      rsp_arb_reg   <= 1'b0;
      rsp_err_reg   <= 1'b0;
    end else begin
      rsp_valid_reg <= 1'b0;
      rsp_bit_reg   <= 1'b0;
      rsp_arb_reg   <= 1'b0;
      rsp_err_reg   <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (cmd_valid) begin
            if (cmd_legal) begin
              state_reg     <= ST_RUN;
              cmd_type_reg  <= cmd_type;
              cmd_bit_reg   <= cmd_bit;
              n_reg         <= n_capture;
              phase_idx_reg <= first_idx;
              repeated_reg  <= owned_reg;
              loaded_reg    <= 1'b0;
              scl_low_reg   <= first_drive[1];
              sda_low_reg   <= first_drive[0];
            end else begin
              // Bus not owned: reject without touching the lines.
              rsp_valid_reg <= 1'b1;
              rsp_err_reg   <= 1'b1;
            end
          end
        end
        default: begin
          if (timer_load) begin
            loaded_reg <= 1'b1;
          end
          if (done_now) begin
            state_reg     <= ST_IDLE;
            rsp_valid_reg <= 1'b1;
            rsp_arb_reg   <= arb_lost_now;
            rsp_bit_reg   <= (cmd_type_reg == CMD_READ) ? sda_in : 1'b0;
            owned_reg     <= owned_after;
            scl_low_reg   <= owned_after;
            sda_low_reg   <= owned_after ? sda_low_reg : 1'b0;
          end else if (phase_end) begin
            phase_idx_reg <= next_idx;
            loaded_reg    <= 1'b0;
            scl_low_reg   <= next_drive[1];
            sda_low_reg   <= next_drive[0];
          end
        end
      endcase
    end
  end

  assign scl_drive_low = scl_low_reg;
  assign sda_drive_low = sda_low_reg;
  assign rsp_valid     = rsp_valid_reg;
  assign rsp_bit       = rsp_bit_reg;
  assign rsp_arb_lost  = rsp_arb_reg;
  assign rsp_error     = rsp_err_reg;

endmodule

// File: tb/tb_i2c_bit_sequencer.sv
// Bench for i2c_bit_sequencer: models the cycle timer and an open-drain bus with a
// stretching/driving slave; expected responses go through a scoreboard queue.
module tb_i2c_bit_sequencer;

  localparam int BW = 16;

  logic          clock;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_type;
  logic          cmd_bit;
  logic [BW-1:0] half_period;
  logic          rsp_valid;
  logic          rsp_bit;
  logic          rsp_arb_lost;
  logic          rsp_error;
  logic          timer_enable;
  logic          timer_load;
  logic [BW-1:0] timer_count;
  logic          timer_expired;
  logic          scl_drive_low;
  logic          sda_drive_low;
  logic          scl_in;
  logic          sda_in;

  typedef struct {
    int   lat;
    logic rbit;
    logic arb;
    logic err;
  } exp_t;

  exp_t          exp_q[$];
  int            checks = 0;
  int            failures = 0;
  int            rsp_expected = 0;
  int            rsp_seen = 0;
  int            stray_flags = 0;
  logic          mon_en = 1'b0;
  logic          sda_slave = 1'b1;
  int            stretch_left = 0;
  logic [BW-1:0] tmr_cnt;

  i2c_bit_sequencer #(.BIT_WIDTH(BW)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
    .cmd_bit(cmd_bit), .half_period(half_period),
    .rsp_valid(rsp_valid), .rsp_bit(rsp_bit), .rsp_arb_lost(rsp_arb_lost),
    .rsp_error(rsp_error),
    .timer_enable(timer_enable), .timer_load(timer_load), .timer_count(timer_count),
    .timer_expired(timer_expired),
    .scl_drive_low(scl_drive_low), .sda_drive_low(sda_drive_low),
    .scl_in(scl_in), .sda_in(sda_in)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Open-drain bus: a line is low if anyone pulls it; the slave may stretch SCL.
  assign scl_in = !scl_drive_low && (stretch_left == 0);
  assign sda_in = !sda_drive_low && sda_slave;

  // Downstream cycle timer: expires N cycles after the load cycle.
  always @(posedge clock) begin
    if (reset) tmr_cnt <= '0;
    else if (timer_load) tmr_cnt <= timer_count;
    else if (timer_enable && tmr_cnt != '0) tmr_cnt <= tmr_cnt - 1'b1;
  end
  assign timer_expired = timer_enable && (tmr_cnt == 16'd1);

  always @(negedge clock) begin
    if (mon_en) begin
      if (rsp_valid) rsp_seen++;
      else if (rsp_bit || rsp_arb_lost || rsp_error) stray_flags++;
    end
  end

  // Issues one command and reports the cycle (relative to acceptance) of its response.
  task automatic send_cmd(input logic [1:0] t, input logic b, input logic [BW-1:0] hp,
                          input int stretch, output int lat, output logic rb,
                          output logic ra, output logic re, output int sda_rise,
                          output int scl_rise);
    logic prev_sda;
    logic prev_scl;
    int   waited;
    lat = -1; rb = 1'b0; ra = 1'b0; re = 1'b0; sda_rise = -1; scl_rise = -1;
    @(negedge clock);
    waited = 0;
    while (!cmd_ready && waited < 200) begin
      @(negedge clock);
      waited++;
    end
    cmd_type = t; cmd_bit = b; half_period = hp; cmd_valid = 1'b1;
    stretch_left = (stretch > 0) ? stretch + 1 : 0;
    prev_sda = sda_drive_low;
    prev_scl = scl_drive_low;
    @(posedge clock);
    #1 cmd_valid = 1'b0;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clock);
      if (stretch_left > 0 && !scl_drive_low) stretch_left--;
      if (sda_drive_low && !prev_sda && sda_rise < 0) sda_rise = k;
      if (scl_drive_low && !prev_scl && scl_rise < 0) scl_rise = k;
      prev_sda = sda_drive_low;
      prev_scl = scl_drive_low;
      if (rsp_valid) begin
        lat = k; rb = rsp_bit; ra = rsp_arb_lost; re = rsp_error;
        break;
      end
    end
    stretch_left = 0;
  endtask

  task automatic push_exp(input int lat, input logic rbit, input logic arb, input logic err);
    exp_t e;
    e.lat = lat; e.rbit = rbit; e.arb = arb; e.err = err;
    exp_q.push_back(e);
    rsp_expected++;
  endtask

  task automatic test_reset();
    reset = 1'b1; cmd_valid = 1'b1; cmd_type = 2'd0; cmd_bit = 1'b0; half_period = 16'd4;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++;
    if ({scl_drive_low, sda_drive_low, timer_load, timer_enable} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_drives got=%b want=0000",
               {scl_drive_low, sda_drive_low, timer_load, timer_enable});
    end
    checks++;
    if ({cmd_ready, rsp_valid, rsp_bit, rsp_arb_lost, rsp_error} !== 5'b10000) begin
      failures++;
      $display("FAIL reset_handshake got=%b want=10000",
               {cmd_ready, rsp_valid, rsp_bit, rsp_arb_lost, rsp_error});
    end
    cmd_valid = 1'b0;
    reset = 1'b0;
    mon_en = 1'b1;
    @(negedge clock);
    checks++;
    if ({cmd_ready, rsp_valid, scl_drive_low} !== 3'b100) begin
      failures++;
      $display("FAIL reset_release got=%b want=100", {cmd_ready, rsp_valid, scl_drive_low});
    end
  endtask

  task automatic test_start();
    int lat, sr, cr; logic rb, ra, re; exp_t e;
    push_exp(16, 1'b0, 1'b0, 1'b0);
    send_cmd(2'd0, 1'b0, 16'd4, 0, lat, rb, ra, re, sr, cr);
    e = exp_q.pop_front();
    checks++;
    if (lat !== e.lat) begin failures++; $display("FAIL start_lat got=%0d want=%0d", lat, e.lat); end
    checks++;
    if ({rb, ra, re} !== {e.rbit, e.arb, e.err}) begin
      failures++; $display("FAIL start_flags got=%b want=%b", {rb, ra, re}, {e.rbit, e.arb, e.err});
    end
    checks++;
    if (sr !== 6) begin failures++; $display("FAIL start_sda_rise got=%0d want=6", sr); end
    checks++;
    if (cr !== 11) begin failures++; $display("FAIL start_scl_rise got=%0d want=11", cr); end
    checks++;
    if (scl_drive_low !== 1'b1) begin
      failures++; $display("FAIL start_owned_scl got=%b want=1", scl_drive_low);
    end
  endtask

  task automatic test_stretch_read();
    int lat, sr, cr; logic rb, ra, re; exp_t e;
    sda_slave = 1'b1;
    push_exp(1 + 2 * 5 + 20, 1'b1, 1'b0, 1'b0);
    send_cmd(2'd3, 1'b0, 16'd4, 20, lat, rb, ra, re, sr, cr);
    e = exp_q.pop_front();
    checks++;
    if (lat !== e.lat) begin failures++; $display("FAIL read_stretch_lat got=%0d want=%0d", lat, e.lat); end
    checks++;
    if ({rb, ra, re} !== {e.rbit, e.arb, e.err}) begin
      failures++; $display("FAIL read_stretch_flags got=%b want=%b", {rb, ra, re}, {e.rbit, e.arb, e.err});
    end
    sda_slave = 1'b0;
    push_exp(11, 1'b0, 1'b0, 1'b0);
    send_cmd(2'd3, 1'b0, 16'd4, 0, lat, rb, ra, re, sr, cr);
    e = exp_q.pop_front();
    sda_slave = 1'b1;
    checks++;
    if (lat !== e.lat) begin failures++; $display("FAIL read0_lat got=%0d want=%0d", lat, e.lat); end
    checks++;
    if ({rb, ra, re} !== {e.rbit, e.arb, e.err}) begin
      failures++; $display("FAIL read0_flags got=%b want=%b", {rb, ra, re}, {e.rbit, e.arb, e.err});
    end
  endtask

  task automatic test_half_period_zero();
    int lat, sr, cr; logic rb, ra, re; exp_t e;
    push_exp(5, 1'b0, 1'b0, 1'b0);
    send_cmd(2'd2, 1'b0, 16'd0, 0, lat, rb, ra, re, sr, cr);
    e = exp_q.pop_front();
    checks++;
    if ({lat, rb, ra, re} !== {e.lat, e.rbit, e.arb, e.err}) begin
      failures++; $display("FAIL write_hp0 got lat=%0d flags=%b want lat=%0d flags=%b",
                           lat, {rb, ra, re}, e.lat, {e.rbit, e.arb, e.err});
    end
    push_exp(5, 1'b0, 1'b0, 1'b0);
    send_cmd(2'd2, 1'b1, 16'd1, 0, lat, rb, ra, re, sr, cr);
    e = exp_q.pop_front();
    checks++;
    if ({lat, rb, ra, re} !== {e.lat, e.rbit, e.arb, e.err}) begin
      failures++; $display("FAIL write_hp1 got lat=%0d flags=%b want lat=%0d flags=%b",
                           lat, {rb, ra, re}, e.lat, {e.rbit, e.arb, e.err});
    end
  endtask

  task automatic test_repeated_start();
    int lat, sr, cr; logic rb, ra, re; exp_t e;
    push_exp(1 + 4 * 3, 1'b0, 1'b0, 1'b0);
    send_cmd(2'd0, 1'b0, 16'd2, 0, lat, rb, ra, re, sr, cr);
    e = exp_q.pop_front();
    checks++;
    if ({lat, rb, ra, re} !== {e.lat, e.rbit, e.arb, e.err}) begin
      failures++; $display("FAIL rstart got lat=%0d flags=%b want lat=%0d flags=%b",
                           lat, {rb, ra, re}, e.lat, {e.rbit, e.arb, e.err});
    end
  endtask

  task automatic test_stop();
    int lat, sr, cr; logic rb, ra, re; exp_t e;
    push_exp(13, 1'b0, 1'b0, 1'b0);
    send_cmd(2'd1, 1'b0, 16'd3, 0, lat, rb, ra, re, sr, cr);
    e = exp_q.pop_front();
    checks++;
    if ({lat, rb, ra, re} !== {e.lat, e.rbit, e.arb, e.err}) begin
      failures++; $display("FAIL stop got lat=%0d flags=%b want lat=%0d flags=%b",
                           lat, {rb, ra, re}, e.lat, {e.rbit, e.arb, e.err});
    end
    checks++;
    if ({scl_drive_low, sda_drive_low} !== 2'b00) begin
      failures++; $display("FAIL stop_drives got=%b want=00", {scl_drive_low, sda_drive_low});
    end
    push_exp(1, 1'b0, 1'b0, 1'b1);
    send_cmd(2'd3, 1'b0, 16'd2, 0, lat, rb, ra, re, sr, cr);
    e = exp_q.pop_front();
    checks++;
    if ({lat, rb, ra, re} !== {e.lat, e.rbit, e.arb, e.err}) begin
      failures++; $display("FAIL read_unowned got lat=%0d flags=%b want lat=%0d flags=%b",
                           lat, {rb, ra, re}, e.lat, {e.rbit, e.arb, e.err});
    end
  endtask

  task automatic test_arb_loss();
    int lat, sr, cr; logic rb, ra, re; exp_t e;
    sda_slave = 1'b0;
    push_exp(4, 1'b0, 1'b1, 1'b0);
    send_cmd(2'd0, 1'b0, 16'd2, 0, lat, rb, ra, re, sr, cr);
    e = exp_q.pop_front();
    sda_slave = 1'b1;
    checks++;
    if ({lat, rb, ra, re} !== {e.lat, e.rbit, e.arb, e.err}) begin
      failures++; $display("FAIL start_arb got lat=%0d flags=%b want lat=%0d flags=%b",
                           lat, {rb, ra, re}, e.lat, {e.rbit, e.arb, e.err});
    end
    push_exp(16, 1'b0, 1'b0, 1'b0);
    send_cmd(2'd0, 1'b0, 16'd4, 0, lat, rb, ra, re, sr, cr);
    e = exp_q.pop_front();
    checks++;
    if ({lat, rb, ra, re} !== {e.lat, e.rbit, e.arb, e.err}) begin
      failures++; $display("FAIL start2 got lat=%0d flags=%b want lat=%0d flags=%b",
                           lat, {rb, ra, re}, e.lat, {e.rbit, e.arb, e.err});
    end
    sda_slave = 1'b0;
    push_exp(11, 1'b0, 1'b1, 1'b0);
    send_cmd(2'd2, 1'b1, 16'd4, 0, lat, rb, ra, re, sr, cr);
    e = exp_q.pop_front();
    sda_slave = 1'b1;
    checks++;
    if ({lat, rb, ra, re} !== {e.lat, e.rbit, e.arb, e.err}) begin
      failures++; $display("FAIL write_arb got lat=%0d flags=%b want lat=%0d flags=%b",
                           lat, {rb, ra, re}, e.lat, {e.rbit, e.arb, e.err});
    end
    checks++;
    if ({scl_drive_low, sda_drive_low} !== 2'b00) begin
      failures++; $display("FAIL arb_drives got=%b want=00", {scl_drive_low, sda_drive_low});
    end
    push_exp(1, 1'b0, 1'b0, 1'b1);
    send_cmd(2'd2, 1'b0, 16'd4, 0, lat, rb, ra, re, sr, cr);
    e = exp_q.pop_front();
    checks++;
    if ({lat, rb, ra, re} !== {e.lat, e.rbit, e.arb, e.err}) begin
      failures++; $display("FAIL write_after_arb got lat=%0d flags=%b want lat=%0d flags=%b",
                           lat, {rb, ra, re}, e.lat, {e.rbit, e.arb, e.err});
    end
  endtask

  task automatic test_reset_mid_stop();
    int lat, sr, cr; logic rb, ra, re; exp_t e;
    int pulses;
    push_exp(10, 1'b0, 1'b0, 1'b0);
    send_cmd(2'd0, 1'b0, 16'd2, 0, lat, rb, ra, re, sr, cr);
    e = exp_q.pop_front();
    checks++;
    if ({lat, rb, ra, re} !== {e.lat, e.rbit, e.arb, e.err}) begin
      failures++; $display("FAIL start3 got lat=%0d flags=%b want lat=%0d flags=%b",
                           lat, {rb, ra, re}, e.lat, {e.rbit, e.arb, e.err});
    end
    @(negedge clock);
    cmd_type = 2'd1; cmd_bit = 1'b0; half_period = 16'd3; cmd_valid = 1'b1;
    @(posedge clock);
    #1 cmd_valid = 1'b0;
    pulses = 0;
    repeat (5) begin
      @(negedge clock);
      if (rsp_valid) pulses++;
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checks++;
    if ({scl_drive_low, sda_drive_low, cmd_ready} !== 3'b001) begin
      failures++; $display("FAIL mid_reset_state got=%b want=001",
                           {scl_drive_low, sda_drive_low, cmd_ready});
    end
    repeat (20) begin
      @(negedge clock);
      if (rsp_valid) pulses++;
    end
    checks++;
    if (pulses !== 0) begin failures++; $display("FAIL mid_reset_pulses got=%0d want=0", pulses); end
    push_exp(1, 1'b0, 1'b0, 1'b1);
    send_cmd(2'd2, 1'b0, 16'd2, 0, lat, rb, ra, re, sr, cr);
    e = exp_q.pop_front();
    checks++;
    if ({lat, rb, ra, re} !== {e.lat, e.rbit, e.arb, e.err}) begin
      failures++; $display("FAIL mid_reset_unowned got lat=%0d flags=%b want lat=%0d flags=%b",
                           lat, {rb, ra, re}, e.lat, {e.rbit, e.arb, e.err});
    end
  endtask

  task automatic test_back_to_back();
    int lat1, lat2; logic ready_at_rsp; logic [2:0] f1, f2; exp_t e;
    lat1 = -1; lat2 = -1; ready_at_rsp = 1'b0; f1 = 3'b111; f2 = 3'b111;
    push_exp(7, 1'b0, 1'b0, 1'b0);
    push_exp(5, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    cmd_type = 2'd0; cmd_bit = 1'b0; half_period = 16'd1; cmd_valid = 1'b1;
    @(posedge clock);
    #1 cmd_type = 2'd2; cmd_bit = 1'b0; half_period = 16'd1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clock);
      if (rsp_valid) begin
        lat1 = k; ready_at_rsp = cmd_ready; f1 = {rsp_bit, rsp_arb_lost, rsp_error};
        break;
      end
    end
    @(posedge clock);
    #1 cmd_valid = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clock);
      if (rsp_valid) begin
        lat2 = k; f2 = {rsp_bit, rsp_arb_lost, rsp_error};
        break;
      end
    end
    e = exp_q.pop_front();
    checks++;
    if ({lat1, f1} !== {e.lat, e.rbit, e.arb, e.err}) begin
      failures++; $display("FAIL b2b_start got lat=%0d flags=%b want lat=%0d", lat1, f1, e.lat);
    end
    checks++;
    if (ready_at_rsp !== 1'b1) begin
      failures++; $display("FAIL b2b_ready got=%b want=1", ready_at_rsp);
    end
    e = exp_q.pop_front();
    checks++;
    if ({lat2, f2} !== {e.lat, e.rbit, e.arb, e.err}) begin
      failures++; $display("FAIL b2b_write got lat=%0d flags=%b want lat=%0d", lat2, f2, e.lat);
    end
  endtask

  initial begin
    cmd_valid = 1'b0; cmd_type = 2'd0; cmd_bit = 1'b0; half_period = '0; reset = 1'b1;
    test_reset();
    test_start();
    test_stretch_read();
    test_half_period_zero();
    test_repeated_start();
    test_stop();
    test_arb_loss();
    test_reset_mid_stop();
    test_back_to_back();
    repeat (3) @(negedge clock);
    checks++;
    if (rsp_seen !== rsp_expected) begin
      failures++; $display("FAIL rsp_count got=%0d want=%0d", rsp_seen, rsp_expected);
    end
    checks++;
    if (stray_flags !== 0) begin
      failures++; $display("FAIL idle_rsp_flags got=%0d want=0", stray_flags);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_bit_sequencer.md
I2C_BIT_SEQUENCER -- requirements
Module: i2c_bit_sequencer

Interface
REQ-001 The block SHALL have parameter BIT_WIDTH, default 16, giving the width of the half-period and timer count.
REQ-002 The block SHALL have port clock, input, 1, the single clock; all logic SHALL be synchronous to its rising edge.
REQ-003 The block SHALL have port reset, input, 1, a synchronous, active-high reset.
REQ-004 The block SHALL have port cmd_valid, input, 1, which marks a command as present.
REQ-005 The block SHALL have port cmd_ready, output, 1, asserted when the block can accept a command.
REQ-006 The block SHALL have port cmd_type, input, 2, where 0=START, 1=STOP, 2=WRITE and 3=READ.
REQ-007 The block SHALL have port cmd_bit, input, 1, the data bit for WRITE.
REQ-008 The block SHALL have port half_period, input, BIT_WIDTH, the phase length in clock cycles.
REQ-009 The block SHALL have port rsp_valid, output, 1, a one-cycle completion pulse.
REQ-010 The block SHALL have port rsp_bit, output, 1, the sampled SDA value for READ.
REQ-011 The block SHALL have port rsp_arb_lost, output, 1, flagging lost arbitration.
REQ-012 The block SHALL have port rsp_error, output, 1, flagging an illegal command.
REQ-013 The block SHALL have port timer_enable, output, 1, which drives the downstream cycle timer enable.
REQ-014 The block SHALL have port timer_load, output, 1, which drives the cycle timer load_count.
REQ-015 The block SHALL have port timer_count, output, BIT_WIDTH, which drives the cycle timer count.
REQ-016 The block SHALL have port timer_expired, input, 1, which carries the cycle timer expired output.
REQ-017 The block SHALL have ports scl_drive_low and sda_drive_low, outputs, 1 each, where 1 pulls the line low and 0 releases it.
REQ-018 The block SHALL have ports scl_in and sda_in, inputs, 1 each, carrying the already-synchronised bus levels.

Function
REQ-019 cmd_ready SHALL equal 1 exactly when the state is IDLE; a command SHALL be accepted on a clock edge where cmd_valid and cmd_ready are both 1.
REQ-020 On acceptance the block SHALL capture cmd_type, cmd_bit and half_period; a captured half_period of 0 SHALL be treated as 1 (N = max(half_period,1)).
REQ-021 The block SHALL drive timer_count with the captured N and assert timer_enable in every non-IDLE cycle.
REQ-022 A command SHALL execute as an ordered list of phases, each with fixed scl_drive_low and sda_drive_low values registered at phase entry.
REQ-023 Each phase SHALL pulse timer_load for one cycle: in its first cycle for SCL-low phases, and in the first cycle scl_in=1 for SCL-released phases (clock stretching).
REQ-024 timer_expired SHALL be ignored in any cycle where timer_load=1.
REQ-025 A phase SHALL end in the first cycle after its load in which timer_expired=1, so an unstretched phase lasts N+1 cycles.
REQ-026 START when the bus is not owned SHALL run phases (SCL rel, SDA rel), (SCL rel, SDA low), (SCL low, SDA low).
REQ-027 START when the bus is owned (repeated start) SHALL prepend the phase (SCL low, SDA rel).
REQ-028 STOP SHALL run phases (SCL low, SDA low), (SCL rel, SDA low), (SCL rel, SDA rel).
REQ-029 WRITE SHALL run phases (SCL low, SDA=!cmd_bit drive), (SCL rel, same SDA); READ SHALL run the same phases with SDA released.
REQ-030 sda_in SHALL be sampled in the final cycle of each SCL-released phase; READ SHALL return that sample on rsp_bit.
REQ-031 rsp_arb_lost SHALL be set when SDA was released but a sample reads 0, and when the first START phase samples scl_in=0 or sda_in=0; the block SHALL then release both lines, clear bus ownership and complete immediately.
REQ-032 rsp_valid SHALL pulse in the cycle after the final phase ends, with the state returned to IDLE in that same cycle, so a back-to-back command can be accepted in the rsp_valid cycle.
REQ-033 rsp_bit, rsp_arb_lost and rsp_error SHALL be valid only while rsp_valid=1 and SHALL be 0 otherwise.
REQ-034 Bus ownership SHALL be set by a completed START, cleared by STOP or arbitration loss.
REQ-035 In IDLE the block SHALL hold scl_drive_low=1 while the bus is owned and 0 otherwise.
REQ-036 WRITE, READ or STOP accepted while the bus is not owned SHALL drive no lines and SHALL pulse rsp_valid with rsp_error=1 in the next cycle.
REQ-037 Latency SHALL be: acceptance edge at the end of cycle T; rsp_valid in cycle T+1+P*(N+1)+S, where P is the phase count and S is the total number of stretch cycles.

Reset
REQ-038 While reset=1 the block SHALL go to IDLE, clear bus ownership, drive scl_drive_low=0, sda_drive_low=0, timer_load=0, timer_enable=0, all rsp_* outputs 0, and ignore cmd_valid.
REQ-039 Reset asserted mid-command SHALL abort the command with no rsp_valid pulse.

Verification
REQ-040 Reset check: after reset, all drives are 0, cmd_ready=1 and rsp_valid=0.
REQ-041 START with N=4, scl_in=!scl_drive_low, accepted at cycle 0: sda_drive_low rises at cycle 6, scl_drive_low rises at cycle 11, rsp_valid is asserted at cycle 16 with no flags.
REQ-042 After START, READ with N=4 and scl_in held 0 for 20 cycles after release: rsp_valid is delayed exactly 20 cycles versus the unstretched case, and rsp_bit equals sda_in.
REQ-043 After START, WRITE cmd_bit=1 with sda_in forced 0 during the high phase: rsp_arb_lost=1, both drives are 0 afterwards, and a following WRITE returns rsp_error=1.
REQ-044 WRITE with half_period=0: the block behaves identically to N=1, with rsp_valid at cycle 5.
REQ-045 Reset asserted mid-STOP: no rsp_valid pulse, both drives are 0 in the next cycle, and the block is IDLE and not owned.
